stack_1r1w_wbuf_ramwrap: RTL and testbench

STACK_1R1W_WBUF_RAMWRAP -- requirements
Module: stack_1r1w_wbuf_ramwrap

---
 rtl/stack_1r1w_wbuf_ramwrap_pkg.sv | 31 +++
 rtl/wbuf_cam_ramwrap.sv | 132 +++++++++++++
 rtl/stack_1r1w_wbuf_ramwrap.sv | 197 +++++++++++++++++++
 tb/tb_stack_1r1w_wbuf_ramwrap.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_1r1w_wbuf_ramwrap_pkg.sv
// Shared decode helpers and write-buffer entry record for the banked stack wrapper.
// The entry record is sized by the package widths, which match the wrapper defaults.
package stack_1r1w_wbuf_ramwrap_pkg;

    localparam int ENT_WIDTH   = 32;
    localparam int ENT_BITWBNK = 2;
    localparam int ENT_BITWROW = 8;

    typedef struct packed {
        logic                   vld;
        logic [ENT_BITWBNK-1:0] bnk;
        logic [ENT_BITWROW-1:0] row;
        logic [ENT_WIDTH-1:0]   msk;
        logic [ENT_WIDTH-1:0]   dat;
    } wbuf_ent_t;

    function automatic int unsigned dec_bank(
        input int unsigned adr,
        input int unsigned nbnk
    );
        return adr % nbnk;
    endfunction

    function automatic int unsigned dec_row(
        input int unsigned adr,
        input int unsigned nbnk
    );
        return adr / nbnk;
    endfunction

endpackage

// File: rtl/wbuf_cam_ramwrap.sv
// Write buffer: address CAM, merge, allocate, drain select and occupancy count.
// Buffered writes are those that collided with a read on the same bank.
module wbuf_cam_ramwrap
    import stack_1r1w_wbuf_ramwrap_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int BITWBNK = 2,
    parameter int BITWROW = 8,
    parameter int WBUFDEP = 4,
    parameter int BITWBUF = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [BITWBNK-1:0] wr_bnk,
    input  logic [BITWROW-1:0] wr_row,
    input  logic [WIDTH-1:0]   wr_bw,
    input  logic [WIDTH-1:0]   wr_din,
    input  logic               rd_en,
    input  logic [BITWBNK-1:0] rd_bnk,
    input  logic [BITWROW-1:0] rd_row,
    output logic               wr_direct,
    output logic               drn_vld,
    output logic [BITWBNK-1:0] drn_bnk,
    output logic [BITWROW-1:0] drn_row,
    output logic [WIDTH-1:0]   drn_msk,
    output logic [WIDTH-1:0]   drn_dat,
    output logic               rd_hit,
    output logic [WIDTH-1:0]   rd_msk,
    output logic [WIDTH-1:0]   rd_dat,
    output logic [BITWBUF:0]   cnt
);

    wbuf_ent_t ent [WBUFDEP];

    logic [WBUFDEP-1:0] wr_hit_vec;
    logic [WBUFDEP-1:0] rd_hit_vec;
    logic [WBUFDEP-1:0] drn_ok;
    logic               wr_hit;
    logic               rd_conf;
    logic               alloc;
    logic               free_vld;
    logic [BITWBUF-1:0] free_idx;
    logic [BITWBUF-1:0] drn_idx;
    logic [BITWBUF-1:0] rd_idx;

    always_comb begin
        wr_hit_vec = '0;
        rd_hit_vec = '0;
        for (int i = 0; i < WBUFDEP; i++) begin
            wr_hit_vec[i] = wr_en && ent[i].vld &&
                            ent[i].bnk == wr_bnk && ent[i].row == wr_row;
            rd_hit_vec[i] = rd_en && ent[i].vld &&
                            ent[i].bnk == rd_bnk && ent[i].row == rd_row;
        end
    end

    assign wr_hit    = |wr_hit_vec;
    assign rd_conf   = rd_en && (rd_bnk == wr_bnk);
    assign wr_direct = wr_en && !wr_hit && !rd_conf;
    assign alloc     = wr_en && !wr_hit && rd_conf;

    // An entry being merged into must stay put so the merge is not lost.
    always_comb begin
        drn_ok = '0;
        for (int i = 0; i < WBUFDEP; i++) begin
            drn_ok[i] = ent[i].vld && !wr_hit_vec[i] &&
                        !(rd_en && ent[i].bnk == rd_bnk) &&
                        !(wr_direct && ent[i].bnk == wr_bnk);
        end
    end

    always_comb begin
        free_vld = 1'b0;
        free_idx = '0;
        drn_vld  = 1'b0;
        drn_idx  = '0;
        rd_hit   = 1'b0;
        rd_idx   = '0;
        for (int i = WBUFDEP - 1; i >= 0; i--) begin
            if (!ent[i].vld) begin
                free_vld = 1'b1;
                free_idx = BITWBUF'(i);
            end
            if (drn_ok[i]) begin
                drn_vld = 1'b1;
                drn_idx = BITWBUF'(i);
            end
            if (rd_hit_vec[i]) begin
                rd_hit = 1'b1;
                rd_idx = BITWBUF'(i);
            end
        end
    end

    assign drn_bnk = ent[drn_idx].bnk;
    assign drn_row = ent[drn_idx].row;
    assign drn_msk = ent[drn_idx].msk;
    assign drn_dat = ent[drn_idx].dat;
    assign rd_msk  = rd_hit ? ent[rd_idx].msk : '0;
    assign rd_dat  = ent[rd_idx].dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WBUFDEP; i++) begin
                ent[i].vld <= 1'b0;
            end
        end else begin
            for (int i = 0; i < WBUFDEP; i++) begin
                if (wr_hit_vec[i]) begin
                    ent[i].msk <= ent[i].msk | wr_bw;
                    ent[i].dat <= (ent[i].dat & ~wr_bw) | (wr_din & wr_bw);
                end
            end
            if (drn_vld) begin
                ent[drn_idx].vld <= 1'b0;
            end
            if (alloc && free_vld) begin
                ent[free_idx] <= '{vld: 1'b1, bnk: wr_bnk, row: wr_row,
                                   msk: wr_bw, dat: wr_din};
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < WBUFDEP; i++) begin
            cnt = cnt + {{BITWBUF{1'b0}}, ent[i].vld};
        end
    end

endmodule

// File: rtl/stack_1r1w_wbuf_ramwrap.sv
// 1R1W logical memory over single-port SRAM banks; read/write bank collisions
// are absorbed by a small write buffer that forwards into later reads.
module stack_1r1w_wbuf_ramwrap
    import stack_1r1w_wbuf_ramwrap_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUMADDR    = 1024,
    parameter int BITADDR    = 10,
    parameter int NUMWBNK    = 4,
    parameter int BITWBNK    = 2,
    parameter int NUMWROW    = 256,
    parameter int BITWROW    = 8,
    parameter int WBUFDEP    = 4,
    parameter int BITWBUF    = 2,
    parameter int SRAM_DELAY = 2,
    parameter int FLOPMEM    = 0,
    parameter int FLOPOUT    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write,
    input  logic [BITADDR-1:0]         wr_adr,
    input  logic [WIDTH-1:0]           bw,
    input  logic [WIDTH-1:0]           din,
    output logic                       wr_rdy,
    input  logic                       read,
    input  logic [BITADDR-1:0]         rd_adr,
    output logic                       rd_vld,
    output logic [WIDTH-1:0]           rd_dout,
    output logic [NUMWBNK-1:0]         mem_write,
    output logic [NUMWBNK*BITWROW-1:0] mem_wr_adr,
    output logic [NUMWBNK*WIDTH-1:0]   mem_bw,
    output logic [NUMWBNK*WIDTH-1:0]   mem_din,
    output logic [NUMWBNK-1:0]         mem_read,
    output logic [NUMWBNK*BITWROW-1:0] mem_rd_adr,
    input  logic [NUMWBNK*WIDTH-1:0]   mem_rd_dout,
    output logic [BITWBUF:0]           wbuf_cnt
);

    logic [BITWBNK-1:0] wr_bnk;
    logic [BITWBNK-1:0] rd_bnk;
    logic [BITWROW-1:0] wr_row;
    logic [BITWROW-1:0] rd_row;
    logic               wr_ok;
    logic               wr_en;
    logic               rd_en;

    assign wr_bnk = BITWBNK'(dec_bank(32'(wr_adr), NUMWBNK));
    assign wr_row = BITWROW'(dec_row(32'(wr_adr), NUMWBNK));
    assign rd_bnk = BITWBNK'(dec_bank(32'(rd_adr), NUMWBNK));
    assign rd_row = BITWROW'(dec_row(32'(rd_adr), NUMWBNK));

    // Writes beyond the logical depth have no backing row and are dropped.
    assign wr_ok  = (32'(wr_adr) < 32'(NUMADDR)) &&
                    (dec_row(32'(wr_adr), NUMWBNK) < 32'(NUMWROW));
    assign wr_rdy = !rst && (wbuf_cnt < (BITWBUF+1)'(WBUFDEP));
    assign wr_en  = write && wr_rdy && wr_ok;
    assign rd_en  = read && !rst;

    logic               wr_direct;
    logic               drn_vld;
    logic [BITWBNK-1:0] drn_bnk;
    logic [BITWROW-1:0] drn_row;
    logic [WIDTH-1:0]   drn_msk;
    logic [WIDTH-1:0]   drn_dat;
    logic               rd_hit;
    logic [WIDTH-1:0]   rd_msk;
    logic [WIDTH-1:0]   rd_dat;

    wbuf_cam_ramwrap #(
        .WIDTH   (WIDTH),
        .BITWBNK (BITWBNK),
        .BITWROW (BITWROW),
        .WBUFDEP (WBUFDEP),
        .BITWBUF (BITWBUF)
    ) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_bnk    (wr_bnk),
        .wr_row    (wr_row),
        .wr_bw     (bw),
        .wr_din    (din),
        .rd_en     (rd_en),
        .rd_bnk    (rd_bnk),
        .rd_row    (rd_row),
        .wr_direct (wr_direct),
        .drn_vld   (drn_vld),
        .drn_bnk   (drn_bnk),
        .drn_row   (drn_row),
        .drn_msk   (drn_msk),
        .drn_dat   (drn_dat),
        .rd_hit    (rd_hit),
        .rd_msk    (rd_msk),
        .rd_dat    (rd_dat),
        .cnt       (wbuf_cnt)
    );

    logic [NUMWBNK-1:0] dir_sel;
    logic [NUMWBNK-1:0] drn_sel;

    // Drain and direct write never share a bank, so each slice picks its owner.
    always_comb begin
        dir_sel    = '0;
        drn_sel    = '0;
        mem_read   = '0;
        mem_write  = '0;
        mem_rd_adr = '0;
        mem_wr_adr = '0;
        mem_bw     = '0;
        mem_din    = '0;
        for (int b = 0; b < NUMWBNK; b++) begin
            dir_sel[b]   = wr_direct && (wr_bnk == BITWBNK'(b));
            drn_sel[b]   = drn_vld && (drn_bnk == BITWBNK'(b));
            mem_read[b]  = rd_en && (rd_bnk == BITWBNK'(b));
            mem_write[b] = dir_sel[b] || drn_sel[b];
            mem_rd_adr[b*BITWROW +: BITWROW] = rd_row;
            mem_wr_adr[b*BITWROW +: BITWROW] = dir_sel[b] ? wr_row : drn_row;
            mem_bw[b*WIDTH +: WIDTH]         = dir_sel[b] ? bw : drn_msk;
            mem_din[b*WIDTH +: WIDTH]        = dir_sel[b] ? din : drn_dat;
        end
    end

    logic [SRAM_DELAY-1:0] p_vld;
    logic [BITWBNK-1:0]    p_bnk [SRAM_DELAY];
    logic [WIDTH-1:0]      p_msk [SRAM_DELAY];
    logic [WIDTH-1:0]      p_dat [SRAM_DELAY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_vld <= '0;
        end else begin
            p_vld[0] <= rd_en;
            for (int k = 1; k < SRAM_DELAY; k++) begin
                p_vld[k] <= p_vld[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        p_bnk[0] <= rd_bnk;
        p_msk[0] <= rd_hit ? rd_msk : '0;
        p_dat[0] <= rd_dat;
        for (int k = 1; k < SRAM_DELAY; k++) begin
            p_bnk[k] <= p_bnk[k-1];
            p_msk[k] <= p_msk[k-1];
            p_dat[k] <= p_dat[k-1];
        end
    end

    logic [WIDTH-1:0] bank_dout;
    logic             a_vld;
    logic [WIDTH-1:0] a_dat;

    always_comb begin
        bank_dout = '0;
        for (int b = 0; b < NUMWBNK; b++) begin
            if (p_bnk[SRAM_DELAY-1] == BITWBNK'(b)) begin
                bank_dout = mem_rd_dout[b*WIDTH +: WIDTH];
            end
        end
    end

    assign a_vld = p_vld[SRAM_DELAY-1];
    assign a_dat = (p_dat[SRAM_DELAY-1] & p_msk[SRAM_DELAY-1]) |
                   (bank_dout & ~p_msk[SRAM_DELAY-1]);

    logic             m_vld;
    logic [WIDTH-1:0] m_dat;

    if (FLOPMEM != 0) begin : g_flopmem
        always_ff @(posedge clk or posedge rst) begin
            if (rst) m_vld <= 1'b0;
            else     m_vld <= a_vld;
        end
        always_ff @(posedge clk) begin
            m_dat <= a_dat;
        end
    end else begin : g_nomem
        assign m_vld = a_vld;
        assign m_dat = a_dat;
    end

    if (FLOPOUT != 0) begin : g_flopout
        always_ff @(posedge clk or posedge rst) begin
            if (rst) rd_vld <= 1'b0;
            else     rd_vld <= m_vld;
        end
        always_ff @(posedge clk) begin
            rd_dout <= m_dat;
        end
    end else begin : g_noout
        assign rd_vld  = m_vld;
        assign rd_dout = m_dat;
    end

endmodule

// File: tb/tb_stack_1r1w_wbuf_ramwrap.sv
// Directed bench: SRAM bank model, logical memory model with read scoreboard.
module tb_stack_1r1w_wbuf_ramwrap;

    localparam int W  = 32;
    localparam int NB = 4;
    localparam int BR = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            write = 1'b0;
    logic [9:0]      wr_adr = '0;
    logic [W-1:0]    bw = '0;
    logic [W-1:0]    din = '0;
    logic            wr_rdy;
    logic            read = 1'b0;
    logic [9:0]      rd_adr = '0;
    logic            rd_vld;
    logic [W-1:0]    rd_dout;
    logic [NB-1:0]   mem_write;
    logic [NB*BR-1:0] mem_wr_adr;
    logic [NB*W-1:0] mem_bw;
    logic [NB*W-1:0] mem_din;
    logic [NB-1:0]   mem_read;
    logic [NB*BR-1:0] mem_rd_adr;
    logic [NB*W-1:0] mem_rd_dout;
    logic [2:0]      wbuf_cnt;
    logic            exp_acc = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stack_1r1w_wbuf_ramwrap dut (
        .clk         (clk),
        .rst         (rst),
        .write       (write),
        .wr_adr      (wr_adr),
        .bw          (bw),
        .din         (din),
        .wr_rdy      (wr_rdy),
        .read        (read),
        .rd_adr      (rd_adr),
        .rd_vld      (rd_vld),
        .rd_dout     (rd_dout),
        .mem_write   (mem_write),
        .mem_wr_adr  (mem_wr_adr),
        .mem_bw      (mem_bw),
        .mem_din     (mem_din),
        .mem_read    (mem_read),
        .mem_rd_adr  (mem_rd_adr),
        .mem_rd_dout (mem_rd_dout),
        .wbuf_cnt    (wbuf_cnt)
    );

    // Single-port SRAM banks with a two-cycle read latency
    logic [W-1:0] sram [NB][256];
    logic [W-1:0] s1 [NB];
    logic [W-1:0] s2 [NB];

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            s2[b] <= s1[b];
            if (mem_read[b])
                s1[b] <= sram[b][mem_rd_adr[b*BR +: BR]];
            if (mem_write[b])
                sram[b][mem_wr_adr[b*BR +: BR]] <=
                    (sram[b][mem_wr_adr[b*BR +: BR]] & ~mem_bw[b*W +: W]) |
                    (mem_din[b*W +: W] & mem_bw[b*W +: W]);
        end
    end

    always_comb begin
        for (int b = 0; b < NB; b++) mem_rd_dout[b*W +: W] = s2[b];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Logical memory model and read scoreboard
    typedef struct {
        int           due;
        logic [W-1:0] val;
    } exp_t;

    logic [W-1:0] model [1024];
    exp_t q[$];
    int cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            chk("rst_rd_vld", {63'd0, rd_vld}, 64'd0);
            chk("rst_mem_write", {60'd0, mem_write}, 64'd0);
            chk("rst_mem_read", {60'd0, mem_read}, 64'd0);
            chk("rst_wbuf_cnt", {61'd0, wbuf_cnt}, 64'd0);
            chk("rst_wr_rdy", {63'd0, wr_rdy}, 64'd0);
        end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("rd_vld", {63'd0, rd_vld}, 64'd1);
                chk("rd_dout", {32'd0, rd_dout}, {32'd0, q[0].val});
                void'(q.pop_front());
            end else begin
                chk("rd_vld_idle", {63'd0, rd_vld}, 64'd0);
            end
            chk("bank_rw_excl", {60'd0, mem_write & mem_read}, 64'd0);
            if (write) chk("wr_rdy", {63'd0, wr_rdy}, {63'd0, exp_acc});
            if (read) q.push_back('{due: cyc + 2, val: model[rd_adr]});
            if (write && exp_acc)
                model[wr_adr] = (model[wr_adr] & ~bw) | (din & bw);
        end
    end

    task automatic step(input logic w, input logic [9:0] wa, input logic [W-1:0] wb,
                        input logic [W-1:0] wd, input logic r, input logic [9:0] ra,
                        input logic acc);
        @(posedge clk);
        #1;
        write = w; wr_adr = wa; bw = wb; din = wd;
        read = r; rd_adr = ra; exp_acc = acc;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 10'd0, '0, '0, 1'b0, 10'd0, 1'b1);
    endtask

    task automatic rst_step(input logic v);
        @(posedge clk);
        #1;
        rst = v; write = 1'b0; read = 1'b0; exp_acc = 1'b1;
        @(negedge clk);
    endtask

    localparam logic [W-1:0] ONES = 32'hFFFF_FFFF;

    initial begin
        for (int b = 0; b < NB; b++) begin
            s1[b] = '0;
            s2[b] = '0;
            for (int r = 0; r < 256; r++) sram[b][r] = '0;
        end
        for (int a = 0; a < 1024; a++) model[a] = '0;

        repeat (3) @(negedge clk);
        chk("reset_cnt", {61'd0, wbuf_cnt}, 64'd0);
        chk("reset_rdy", {63'd0, wr_rdy}, 64'd0);
        rst_step(1'b0);
        chk("rdy_after_release", {63'd0, wr_rdy}, 64'd1);

        // Direct write then read-back
        step(1'b1, 10'h005, ONES, 32'hAABB_CCDD, 1'b0, 10'h0, 1'b1);
        chk("direct_mem_write", {60'd0, mem_write}, 64'b0010);
        chk("direct_row", {56'd0, mem_wr_adr[15:8]}, 64'd1);
        chk("direct_din", {32'd0, mem_din[63:32]}, 64'hAABB_CCDD);
        step(1'b0, 10'h0, '0, '0, 1'b1, 10'h005, 1'b1);
        chk("read_bank", {60'd0, mem_read}, 64'b0010);
        chk("read_row", {56'd0, mem_rd_adr[15:8]}, 64'd1);
        idle();
        idle();
        chk("readback_vld", {63'd0, rd_vld}, 64'd1);
        chk("readback_dat", {32'd0, rd_dout}, 64'hAABB_CCDD);

        // Collision buffering, forwarding, drain
        step(1'b1, 10'h008, ONES, 32'h1234_5678, 1'b0, 10'h0, 1'b1);
        chk("pre_write_bank0", {60'd0, mem_write}, 64'b0001);
        step(1'b1, 10'h008, 32'h0000_00FF, 32'h0000_00FF, 1'b1, 10'h004, 1'b1);
        chk("conflict_no_write", {60'd0, mem_write}, 64'd0);
        chk("conflict_read", {60'd0, mem_read}, 64'b0001);
        step(1'b0, 10'h0, '0, '0, 1'b1, 10'h008, 1'b1);
        chk("buffered_cnt", {61'd0, wbuf_cnt}, 64'd1);
        chk("no_drain_busy", {60'd0, mem_write}, 64'd0);
        idle();
        chk("drain_write", {60'd0, mem_write}, 64'b0001);
        chk("drain_row", {56'd0, mem_wr_adr[7:0]}, 64'd2);
        chk("drain_bw", {32'd0, mem_bw[31:0]}, 64'h0000_00FF);
        chk("drain_din", {32'd0, mem_din[31:0]}, 64'h0000_00FF);
        idle();
        chk("drained_cnt", {61'd0, wbuf_cnt}, 64'd0);
        chk("fwd_dout", {32'd0, rd_dout}, 64'h1234_56FF);

        // Merge of two partial writes into one entry
        step(1'b1, 10'h008, 32'h0000_FFFF, 32'h1111_2222, 1'b1, 10'h000, 1'b1);
        step(1'b1, 10'h008, 32'hFFFF_0000, 32'h3333_4444, 1'b1, 10'h000, 1'b1);
        chk("merge_no_write", {60'd0, mem_write}, 64'd0);
        chk("merge_cnt_a", {61'd0, wbuf_cnt}, 64'd1);
        step(1'b0, 10'h0, '0, '0, 1'b1, 10'h000, 1'b1);
        chk("merge_cnt_b", {61'd0, wbuf_cnt}, 64'd1);
        idle();
        chk("merge_drain", {60'd0, mem_write}, 64'b0001);
        chk("merge_bw", {32'd0, mem_bw[31:0]}, 64'hFFFF_FFFF);
        chk("merge_din", {32'd0, mem_din[31:0]}, 64'h3333_2222);
        step(1'b0, 10'h0, '0, '0, 1'b1, 10'h008, 1'b1);
        idle();
        idle();
        chk("merge_read", {32'd0, rd_dout}, 64'h3333_2222);

        // Fill the buffer under continuous bank-0 reads
        for (int i = 0; i < 4; i++)
            step(1'b1, 10'(16 + 4 * i), ONES, 32'hA000_0000 + i, 1'b1, 10'h000, 1'b1);
        step(1'b1, 10'h020, ONES, 32'hDEAD_BEEF, 1'b1, 10'h000, 1'b0);
        chk("full_cnt", {61'd0, wbuf_cnt}, 64'd4);
        chk("full_rdy", {63'd0, wr_rdy}, 64'd0);
        chk("full_no_write", {60'd0, mem_write}, 64'd0);
        step(1'b0, 10'h0, '0, '0, 1'b1, 10'h000, 1'b1);
        chk("full_cnt_hold", {61'd0, wbuf_cnt}, 64'd4);
        repeat (4) idle();
        step(1'b0, 10'h0, '0, '0, 1'b1, 10'h010, 1'b1);
        chk("full_drained", {61'd0, wbuf_cnt}, 64'd0);
        for (int i = 1; i < 5; i++)
            step(1'b0, 10'h0, '0, '0, 1'b1, 10'(16 + 4 * i), 1'b1);
        idle();
        idle();
        chk("ignored_write", {32'd0, rd_dout}, 64'd0);

        // Reset with pending buffered writes and a read in flight
        for (int i = 0; i < 3; i++)
            step(1'b1, 10'(16 + 4 * i), ONES, 32'hC000_0000 + i, 1'b1, 10'h000, 1'b1);
        step(1'b0, 10'h0, '0, '0, 1'b1, 10'h000, 1'b1);
        chk("pre_rst_cnt", {61'd0, wbuf_cnt}, 64'd3);
        rst_step(1'b1);
        chk("mid_rst_cnt", {61'd0, wbuf_cnt}, 64'd0);
        chk("mid_rst_vld", {63'd0, rd_vld}, 64'd0);
        rst_step(1'b1);
        rst_step(1'b0);
        chk("post_rst_rdy", {63'd0, wr_rdy}, 64'd1);
        step(1'b0, 10'h0, '0, '0, 1'b1, 10'h005, 1'b1);
        idle();
        idle();
        chk("post_rst_read", {32'd0, rd_dout}, 64'hAABB_CCDD);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
